// File: rtl/bank_read_streamer.sv
// Strided read sequencer for the memory bank read port.
// Captures one-cycle-latency read data into a skid FIFO and streams it out.
module bank_read_streamer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  accepted;
    logic [LEN_W-1:0]  issued_next;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] next_addr;
    logic              pending;

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_count;

    logic push;
    logic pop;
    logic credit;
    logic issue_ok;

    assign push      = pending;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_mem[rd_ptr];
    assign out_last  = out_valid && (accepted == len_q - LEN_W'(1));

    // Words already buffered, the word arriving next edge and the read being
    // issued now all hold a slot; pops are ignored so overflow is impossible.
    assign credit = (fifo_count + CW'(pending) + CW'(mem_re)) < CW'(DEPTH);

    assign issue_ok    = (state == RUN) && (issued != len_q) && credit;
    assign issued_next = issued + LEN_W'(issue_ok);

    // Skid FIFO: capture bank data only when a read was issued last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_rd_data;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    // Transfer FSM with registered read port and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_re      <= 1'b0;
            mem_rd_addr <= '0;
            pending     <= 1'b0;
            len_q       <= '0;
            stride_q    <= '0;
            next_addr   <= '0;
            issued      <= '0;
            accepted    <= '0;
        end else begin
            pending <= mem_re;
            done    <= 1'b0;
            mem_re  <= 1'b0;
            if (pop) begin
                accepted <= accepted + LEN_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        accepted <= '0;
                        len_q    <= length;
                        stride_q <= stride;
                        if (length != '0) begin
                            state       <= RUN;
                            mem_re      <= 1'b1;
                            mem_rd_addr <= base_addr;
                            next_addr   <= base_addr + stride;
                            issued      <= LEN_W'(1);
                        end else begin
                            state  <= DONE;
                            done   <= 1'b1;
                            issued <= '0;
                        end
                    end
                end
                RUN: begin
                    if (issue_ok) begin
                        mem_re      <= 1'b1;
                        mem_rd_addr <= next_addr;
                        next_addr   <= next_addr + stride_q;
                        issued      <= issued_next;
                    end
                    if (issued_next == len_q) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bank_read_streamer.sv
// Directed bench for bank_read_streamer with a queue-based transfer model.
// Bank returns a poison word whenever no read was issued.
module tb_bank_read_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  stride;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic        mem_re;
    logic [9:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    bank_read_streamer #(
        .ADDR_W(10),
        .DATA_W(16),
        .DEPTH (4),
        .LEN_W (11)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .stride     (stride),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .mem_re     (mem_re),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memval(input int a);
        return 16'(a % 1024) + 16'h0100;
    endfunction

    // Bank model: one-cycle latency, poison data when idle
    always @(posedge clk) begin
        if (mem_re) mem_rd_data <= memval(int'(mem_rd_addr));
        else        mem_rd_data <= 16'hDEAD;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Model state
    logic [9:0]  aq[$];
    logic [15:0] dq[$];
    logic [15:0] got[$];
    logic [9:0]  alog[$];
    bit open = 0;
    bit done_due = 0;
    int iss_n = 0, pop_n = 0, max_out = 0;
    int first_re = -1, first_v = -1, last_hs = -1;
    int done_cyc = -1, done_seen = 0, busy_cnt = 0;
    int start_cyc = 0;

    // Per-cycle compare against the transfer model
    always @(negedge clk) begin
        bit no, nd;
        if (rst) begin
            aq.delete(); dq.delete();
            open = 0; done_due = 0; iss_n = 0; pop_n = 0;
        end else begin
            chk("busy", busy, open);
            chk("done", done, done_due);
            if (done) begin done_seen++; done_cyc = cyc; end
            if (busy) busy_cnt++;
            if (mem_re) begin
                if (aq.size() == 0) chk("re_unexpected", 1, 0);
                else chk("rd_addr", mem_rd_addr, aq.pop_front());
                alog.push_back(mem_rd_addr);
                if (first_re < 0) first_re = cyc;
                iss_n++;
                if (iss_n - pop_n > max_out) max_out = iss_n - pop_n;
                chk("outstanding_le_depth", (iss_n - pop_n) <= 4, 1);
            end
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (dq.size() == 0) chk("valid_unexpected", 1, 0);
                else begin
                    chk("out_data", out_data, dq[0]);
                    chk("out_last", out_last, dq.size() == 1);
                end
            end else begin
                chk("last_without_valid", out_last, 0);
            end
            nd = 0;
            no = open;
            if (done_due) no = 0;
            if (out_valid && out_ready && dq.size() > 0) begin
                got.push_back(out_data);
                if (dq.size() == 1) begin nd = 1; last_hs = cyc; end
                void'(dq.pop_front());
                pop_n++;
            end
            if (start && !open) begin
                no = 1;
                if (length == 0) nd = 1;
                for (int i = 0; i < int'(length); i++) begin
                    int a;
                    a = (int'(base_addr) + i * int'(stride)) % 1024;
                    aq.push_back(10'(a));
                    dq.push_back(memval(a));
                end
            end
            open = no;
            done_due = nd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got.delete(); alog.delete();
        first_re = -1; first_v = -1; last_hs = -1;
        done_cyc = -1; busy_cnt = 0; max_out = 0;
        iss_n = 0; pop_n = 0;
    endtask

    task automatic do_start(input int b, input int s, input int l);
        base_addr = 10'(b);
        stride    = 10'(s);
        length    = 11'(l);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        int d0 = done_seen;
        while (done_seen == d0 && n < max) begin
            tick();
            n++;
        end
        chk("done_timeout", done_seen != d0, 1);
        tick();
        tick();
    endtask

    task automatic chk_seq(input string name, input int b, input int s,
                           input int l);
        chk({name, "_count"}, got.size(), l);
        for (int i = 0; i < l && i < got.size(); i++)
            chk(name, got[i], memval((b + i * s) % 1024));
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        base_addr = '0; stride = '0; length = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_addr", mem_rd_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        rst = 1'b0;
        tick();

        // Basic stream
        clear_log();
        do_start(4, 1, 8);
        wait_done(100);
        chk("basic_first_re", first_re, start_cyc + 1);
        chk("basic_first_valid", first_v, start_cyc + 3);
        chk("basic_back_to_back", last_hs, first_v + 7);
        chk("basic_done_after_last", done_cyc, last_hs + 1);
        chk("basic_first_word", got.size() > 0 ? got[0] : 0, 16'h0104);
        chk("basic_last_word", got.size() > 7 ? got[7] : 0, 16'h010B);
        chk_seq("basic_word", 4, 1, 8);
        chk("basic_busy", busy, 0);

        // Backpressure
        clear_log();
        do_start(4, 1, 8);
        tick();
        out_ready = 1'b0;
        repeat (8) tick();
        chk("bp_stalled_valid", out_valid, 1);
        chk("bp_stalled_re", mem_re, 0);
        out_ready = 1'b1;
        wait_done(100);
        chk("bp_max_outstanding", max_out, 4);
        chk_seq("bp_word", 4, 1, 8);

        // Stride with address wrap
        clear_log();
        do_start(1020, 3, 4);
        wait_done(100);
        chk("wrap_addr_count", alog.size(), 4);
        chk("wrap_addr0", alog.size() > 0 ? alog[0] : 0, 1020);
        chk("wrap_addr1", alog.size() > 1 ? alog[1] : 0, 1023);
        chk("wrap_addr2", alog.size() > 2 ? alog[2] : 0, 2);
        chk("wrap_addr3", alog.size() > 3 ? alog[3] : 0, 5);
        chk_seq("wrap_word", 1020, 3, 4);

        // Zero length
        clear_log();
        d0 = done_seen;
        do_start(7, 1, 0);
        repeat (4) tick();
        chk("zero_done_cycle", done_cyc, start_cyc + 1);
        chk("zero_done_count", done_seen - d0, 1);
        chk("zero_busy_cycles", busy_cnt, 1);
        chk("zero_no_read", first_re, 32'hFFFFFFFF);
        chk("zero_no_valid", first_v, 32'hFFFFFFFF);

        // Start while busy is ignored
        clear_log();
        do_start(4, 1, 8);
        tick();
        tick();
        base_addr = 10'd500; stride = 10'd7; length = 11'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        chk("busy_start_addr0", alog.size() > 0 ? alog[0] : 0, 4);
        chk("busy_start_addr7", alog.size() > 7 ? alog[7] : 0, 11);
        chk_seq("busy_start_word", 4, 1, 8);

        // Reset mid-transfer
        clear_log();
        do_start(4, 1, 8);
        begin
            int n = 0;
            while (got.size() < 3 && n < 50) begin tick(); n++; end
            chk("midrst_reach_3", got.size() >= 3, 1);
        end
        d0 = done_seen;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_re", mem_re, 0);
        repeat (5) tick();
        chk("midrst_no_done", done_seen, d0);
        clear_log();
        do_start(50, 2, 3);
        wait_done(100);
        chk_seq("midrst_fresh_word", 50, 2, 3);

        // Maximum length
        clear_log();
        do_start(0, 1, 2047);
        wait_done(2300);
        chk("max_count", got.size(), 2047);
        chk("max_last_word", got.size() == 2047 ? got[2046] : 0,
            memval(2046 % 1024));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
